// File: rtl/wisc_pkg.sv
// Shared types and widths for the WISC EX/MEM datapath: opcodes, flag bundle, widths.
package wisc_pkg;

  localparam int unsigned DW  = 16;
  localparam int unsigned RW  = 4;
  localparam int unsigned OPW = 4;

  typedef enum logic [OPW-1:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LHB    = 4'hA,
    OP_LLB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_PCS    = 4'hE,
    OP_HLT    = 4'hF
  } opcode_t;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

endpackage

// File: rtl/ex_flag_stage_flag_calc.sv
// Combinational next-flag computation from the EX opcode and ALU result.
module flag_calc
  import wisc_pkg::*;
(
  input  opcode_t         opcode,
  input  logic [DW-1:0]   alu_result,
  input  logic            alu_ovfl,
  input  flags_t          cur,
  output flags_t          nxt
);

  logic zero;

  assign zero = (alu_result == DW'(0));

  always_comb begin
    nxt = cur;
    case (opcode)
      OP_ADD, OP_SUB: begin
        nxt.z = zero;
        nxt.n = alu_result[DW-1];
        nxt.v = alu_ovfl;
      end
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
        nxt.z = zero;
      end
      default: begin
        nxt = cur;
      end
    endcase
  end

endmodule

// File: rtl/ex_flag_stage.sv
// EX/MEM pipeline register plus architectural Z/V/N flag register.
// FLAG_BYPASS_EN: when defined, flag_* show the next-state flags during a capture cycle.
module ex_flag_stage
  import wisc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic [OPW-1:0]  opcode,
  input  logic [DW-1:0]   alu_result,
  input  logic            alu_ovfl,
  input  logic [RW-1:0]   dst_reg,
  input  logic            reg_wr,
  output logic            out_valid,
  output logic [DW-1:0]   out_result,
  output logic [RW-1:0]   out_dst,
  output logic            out_reg_wr,
  output logic            flag_z,
  output logic            flag_v,
  output logic            flag_n
);

  logic   capture;
  flags_t flags_q;
  flags_t flags_d;
  flags_t flags_vis;

  assign capture = in_valid & ~stall & ~flush;

  flag_calc u_flag_calc (
    .opcode     (opcode_t'(opcode)),
    .alu_result (alu_result),
    .alu_ovfl   (alu_ovfl),
    .cur        (flags_q),
    .nxt        (flags_d)
  );

  // Pipeline register: flush beats stall beats capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_dst    <= '0;
      out_reg_wr <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_reg_wr <= 1'b0;
    end else if (stall) begin
      out_valid  <= out_valid;
    end else if (in_valid) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_dst    <= dst_reg;
      out_reg_wr <= reg_wr;
    end else begin
      out_valid  <= 1'b0;
      out_reg_wr <= 1'b0;
    end
  end

  // Flags only move when an instruction actually leaves EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (capture) begin
      flags_q <= flags_d;
    end
  end

`ifdef FLAG_BYPASS_EN
  assign flags_vis = capture ? flags_d : flags_q;
`else
  assign flags_vis = flags_q;
`endif

  assign flag_z = flags_vis.z;
  assign flag_v = flags_vis.v;
  assign flag_n = flags_vis.n;

endmodule

// File: tb/tb_ex_flag_stage.sv
// Directed bench for ex_flag_stage: reset, flag rules per opcode, stall, flush, bypass.
module tb_ex_flag_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [3:0]  opcode;
  logic [15:0] alu_result;
  logic        alu_ovfl;
  logic [3:0]  dst_reg;
  logic        reg_wr;
  logic        out_valid;
  logic [15:0] out_result;
  logic [3:0]  out_dst;
  logic        out_reg_wr;
  logic        flag_z;
  logic        flag_v;
  logic        flag_n;

  int n_cmp = 0;
  int n_err = 0;

  ex_flag_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .stall      (stall),
    .flush      (flush),
    .opcode     (opcode),
    .alu_result (alu_result),
    .alu_ovfl   (alu_ovfl),
    .dst_reg    (dst_reg),
    .reg_wr     (reg_wr),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_dst    (out_dst),
    .out_reg_wr (out_reg_wr),
    .flag_z     (flag_z),
    .flag_v     (flag_v),
    .flag_n     (flag_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drv(input logic v, input logic [3:0] op, input logic [15:0] res,
                     input logic ovf, input logic [3:0] dst, input logic wr,
                     input logic stl, input logic fls);
    in_valid = v; opcode = op; alu_result = res; alu_ovfl = ovf;
    dst_reg = dst; reg_wr = wr; stall = stl; flush = fls;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // flags packed as {z,v,n}
  task automatic test_reset();
    rst_n = 1'b0;
    drv(0, 4'h0, 16'h0, 0, 4'h0, 0, 0, 0);
    cycle(); cycle();
    rst_n = 1'b1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_result !== 16'h0) begin n_err++; $display("FAIL reset_result got=%h exp=0000", out_result); end
    n_cmp++; if ({flag_z, flag_v, flag_n} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b exp=000", {flag_z, flag_v, flag_n}); end
    drv(1, 4'h0, 16'h5555, 0, 4'h3, 1, 0, 0);
    cycle();
    n_cmp++; if ({out_valid, out_result, out_dst, out_reg_wr} !== {1'b1, 16'h5555, 4'h3, 1'b1})
      begin n_err++; $display("FAIL pre_async_load got=%b/%h/%h/%b exp=1/5555/3/1", out_valid, out_result, out_dst, out_reg_wr); end
    drv(0, 4'h0, 16'h0, 0, 4'h0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({out_valid, out_result, out_dst, out_reg_wr} !== {1'b0, 16'h0, 4'h0, 1'b0})
      begin n_err++; $display("FAIL async_reset_regs got=%b/%h/%h/%b exp=0/0000/0/0", out_valid, out_result, out_dst, out_reg_wr); end
    n_cmp++; if ({flag_z, flag_v, flag_n} !== 3'b000) begin n_err++; $display("FAIL async_reset_flags got=%b exp=000", {flag_z, flag_v, flag_n}); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_add_zero();
    drv(1, 4'h0, 16'h0000, 0, 4'h1, 1, 0, 0);
    #1;
`ifdef FLAG_BYPASS_EN
    n_cmp++; if (flag_z !== 1'b1) begin n_err++; $display("FAIL bypass_same_cycle_z got=%b exp=1", flag_z); end
`else
    n_cmp++; if (flag_z !== 1'b0) begin n_err++; $display("FAIL nobypass_same_cycle_z got=%b exp=0", flag_z); end
`endif
    cycle();
    n_cmp++; if ({out_valid, out_result, out_dst, out_reg_wr} !== {1'b1, 16'h0, 4'h1, 1'b1})
      begin n_err++; $display("FAIL add_zero_regs got=%b/%h/%h/%b exp=1/0000/1/1", out_valid, out_result, out_dst, out_reg_wr); end
    n_cmp++; if ({flag_z, flag_v, flag_n} !== 3'b100) begin n_err++; $display("FAIL add_zero_flags got=%b exp=100", {flag_z, flag_v, flag_n}); end
  endtask

  task automatic test_sub_xor();
    drv(1, 4'h1, 16'h8000, 1, 4'h2, 1, 0, 0);
    cycle();
    n_cmp++; if ({flag_z, flag_v, flag_n} !== 3'b011) begin n_err++; $display("FAIL sub_8000_flags got=%b exp=011", {flag_z, flag_v, flag_n}); end
    drv(1, 4'h2, 16'h0000, 0, 4'h2, 0, 0, 0);
    cycle();
    n_cmp++; if ({flag_z, flag_v, flag_n} !== 3'b111) begin n_err++; $display("FAIL xor_zero_flags got=%b exp=111", {flag_z, flag_v, flag_n}); end
    n_cmp++; if ({out_valid, out_reg_wr} !== 2'b10) begin n_err++; $display("FAIL xor_nowr got=%b%b exp=10", out_valid, out_reg_wr); end
  endtask

  task automatic test_no_flag_ops();
    drv(1, 4'h3, 16'hFFFE, 1, 4'h5, 1, 0, 0);
    cycle();
    n_cmp++; if (out_result !== 16'hFFFE) begin n_err++; $display("FAIL red_result got=%h exp=fffe", out_result); end
    n_cmp++; if ({flag_z, flag_v, flag_n} !== 3'b111) begin n_err++; $display("FAIL red_flags got=%b exp=111", {flag_z, flag_v, flag_n}); end
    drv(1, 4'h2, 16'h0001, 0, 4'h5, 1, 0, 0);
    cycle();
    n_cmp++; if ({flag_z, flag_v, flag_n} !== 3'b011) begin n_err++; $display("FAIL xor_nonzero_flags got=%b exp=011", {flag_z, flag_v, flag_n}); end
    drv(1, 4'h7, 16'h0000, 0, 4'h6, 1, 0, 0);
    cycle();
    n_cmp++; if ({flag_z, flag_v, flag_n} !== 3'b011) begin n_err++; $display("FAIL paddsb_flags got=%b exp=011", {flag_z, flag_v, flag_n}); end
    drv(1, 4'h5, 16'h0000, 0, 4'h6, 1, 0, 0);
    cycle();
    n_cmp++; if ({flag_z, flag_v, flag_n} !== 3'b111) begin n_err++; $display("FAIL sra_zero_flags got=%b exp=111", {flag_z, flag_v, flag_n}); end
    drv(1, 4'h1, 16'h7FFF, 0, 4'h6, 1, 0, 0);
    cycle();
    n_cmp++; if ({flag_z, flag_v, flag_n} !== 3'b000) begin n_err++; $display("FAIL sub_7fff_flags got=%b exp=000", {flag_z, flag_v, flag_n}); end
    drv(1, 4'h8, 16'h0000, 1, 4'h7, 1, 0, 0);
    cycle();
    n_cmp++; if ({flag_z, flag_v, flag_n} !== 3'b000) begin n_err++; $display("FAIL lw_flags got=%b exp=000", {flag_z, flag_v, flag_n}); end
    n_cmp++; if ({out_valid, out_result, out_dst} !== {1'b1, 16'h0, 4'h7}) begin n_err++; $display("FAIL lw_regs got=%b/%h/%h exp=1/0000/7", out_valid, out_result, out_dst); end
  endtask

  task automatic test_stall();
    drv(1, 4'h0, 16'h0000, 0, 4'h4, 1, 0, 0);
    cycle();
    drv(1, 4'h0, 16'h1234, 0, 4'h9, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++; if ({out_valid, out_result, out_dst} !== {1'b1, 16'h0, 4'h4})
        begin n_err++; $display("FAIL stall_hold_regs[%0d] got=%b/%h/%h exp=1/0000/4", i, out_valid, out_result, out_dst); end
      n_cmp++; if ({flag_z, flag_v, flag_n} !== 3'b100) begin n_err++; $display("FAIL stall_hold_flags[%0d] got=%b exp=100", i, {flag_z, flag_v, flag_n}); end
    end
    stall = 1'b0;
    cycle();
    n_cmp++; if ({out_valid, out_result, out_dst} !== {1'b1, 16'h1234, 4'h9})
      begin n_err++; $display("FAIL stall_release_regs got=%b/%h/%h exp=1/1234/9", out_valid, out_result, out_dst); end
    n_cmp++; if ({flag_z, flag_v, flag_n} !== 3'b000) begin n_err++; $display("FAIL stall_release_flags got=%b exp=000", {flag_z, flag_v, flag_n}); end
  endtask

  task automatic test_flush();
    drv(1, 4'h0, 16'h0000, 0, 4'h2, 1, 1, 1);
    #1;
    n_cmp++; if (flag_z !== 1'b0) begin n_err++; $display("FAIL flush_comb_z got=%b exp=0", flag_z); end
    cycle();
    n_cmp++; if ({out_valid, out_reg_wr, out_result, out_dst} !== {1'b0, 1'b0, 16'h1234, 4'h9})
      begin n_err++; $display("FAIL flush_regs got=%b/%b/%h/%h exp=0/0/1234/9", out_valid, out_reg_wr, out_result, out_dst); end
    n_cmp++; if ({flag_z, flag_v, flag_n} !== 3'b000) begin n_err++; $display("FAIL flush_flags got=%b exp=000", {flag_z, flag_v, flag_n}); end
    drv(0, 4'h0, 16'h0000, 0, 4'h0, 1, 0, 0);
    cycle();
    n_cmp++; if ({out_valid, out_reg_wr, flag_z} !== 3'b000) begin n_err++; $display("FAIL idle got=%b%b%b exp=000", out_valid, out_reg_wr, flag_z); end
  endtask

  task automatic test_back_to_back();
    drv(1, 4'h0, 16'h0000, 1, 4'h1, 1, 0, 0);
    cycle();
    n_cmp++; if ({flag_z, flag_v, flag_n} !== 3'b110) begin n_err++; $display("FAIL b2b_first got=%b exp=110", {flag_z, flag_v, flag_n}); end
    drv(1, 4'h1, 16'h8001, 0, 4'h2, 1, 0, 0);
    cycle();
    n_cmp++; if ({flag_z, flag_v, flag_n} !== 3'b001) begin n_err++; $display("FAIL b2b_second got=%b exp=001", {flag_z, flag_v, flag_n}); end
    drv(1, 4'h6, 16'h0000, 1, 4'h3, 1, 0, 0);
    cycle();
    n_cmp++; if ({flag_z, flag_v, flag_n} !== 3'b101) begin n_err++; $display("FAIL b2b_ror got=%b exp=101", {flag_z, flag_v, flag_n}); end
    drv(0, 4'h0, 16'h0000, 0, 4'h0, 0, 0, 0);
    cycle();
  endtask

  initial begin
    test_reset();
    test_add_zero();
    test_sub_xor();
    test_no_flag_ops();
    test_stall();
    test_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
